register_shift_universal: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal register built on the same edge-triggered storage.
- Per-cycle modes: hold, shift, rotate, parallel load, synchronous clear/preset.
- Autonomous burst engine performs a programmed number of shifts/rotates after one start pulse, with busy/done handshake.
- Used by later lab experiments (counters, serial links) as the common storage/shift primitive.

---
 rtl/register_shift_universal.sv | 142 ++++++++++++++
 tb/tb_register_shift_universal.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/register_shift_universal.sv
// WIDTH-bit universal register: per-cycle hold/shift/rotate/load/clear/preset,
// plus an autonomous burst engine that runs a programmed number of shift/rotate steps.
module register_shift_universal #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             serial_l,
    input  logic             serial_r,
    input  logic             start,
    input  logic             burst_dir,
    input  logic             burst_rot,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] notout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // One shift/rotate step; left=1 moves toward the MSB, rot=1 recirculates the end bit.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic             left,
        input logic             rot,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        if (left) begin
            if (rot) r = {v[WIDTH-2:0], v[WIDTH-1]};
            else     r = {v[WIDTH-2:0], sl};
        end else begin
            if (rot) r = {v[0], v[WIDTH-1:1]};
            else     r = {sr, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state logic for the burst sequencer and the storage register.
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Start cycle never moves the register, even with a zero count.
                    if (burst_cnt != CNT_ZERO) begin
                        state_d = ST_RUN;
                        cnt_d   = burst_cnt;
                        dir_d   = burst_dir;
                        rot_d   = burst_rot;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    case (mode)
                        3'b000:  reg_d = reg_q;
                        3'b001:  reg_d = shift_step(reg_q, 1'b0, 1'b0, serial_l, serial_r);
                        3'b010:  reg_d = shift_step(reg_q, 1'b1, 1'b0, serial_l, serial_r);
                        3'b011:  reg_d = data;
                        3'b100:  reg_d = shift_step(reg_q, 1'b0, 1'b1, serial_l, serial_r);
                        3'b101:  reg_d = shift_step(reg_q, 1'b1, 1'b1, serial_l, serial_r);
                        3'b110:  reg_d = {WIDTH{1'b0}};
                        3'b111:  reg_d = {WIDTH{1'b1}};
                        default: reg_d = reg_q;
                    endcase
                end
            end
            ST_RUN: begin
                reg_d = shift_step(reg_q, dir_q, rot_q, serial_l, serial_r);
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            reg_q   <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out    = reg_q;
    assign notout = ~reg_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_register_shift_universal.sv
// Bench for register_shift_universal: directed literal checks plus randomized
// stimulus compared every cycle against an arithmetic reference model.
module tb_register_shift_universal;

    localparam int W    = 4;
    localparam int CW   = 3;
    localparam int MASK = (1 << W) - 1;

    logic          clockpulse = 1'b0;
    logic          clear;
    logic [2:0]    mode;
    logic [W-1:0]  data;
    logic          serial_l, serial_r, start, burst_dir, burst_rot;
    logic [CW-1:0] burst_cnt;
    logic [W-1:0]  out, notout;
    logic          busy, done;

    int n_checks = 0;
    int n_errors = 0;

    register_shift_universal #(.WIDTH(W), .CNT_W(CW)) dut (
        .clockpulse(clockpulse), .clear(clear), .mode(mode), .data(data),
        .serial_l(serial_l), .serial_r(serial_r), .start(start),
        .burst_dir(burst_dir), .burst_rot(burst_rot), .burst_cnt(burst_cnt),
        .out(out), .notout(notout), .busy(busy), .done(done)
    );

    always #5 clockpulse = ~clockpulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register value as an integer, remaining burst steps, pending done.
    int m_val = 0, m_left = 0;
    bit m_done = 0, m_dir = 0, m_rot = 0;

    function automatic int mstep(int v, bit left, bit rot, bit sl, bit sr);
        int fill;
        if (left) begin
            fill = rot ? ((v >> (W - 1)) & 1) : int'(sl);
            return ((v << 1) & MASK) | fill;
        end else begin
            fill = rot ? (v & 1) : int'(sr);
            return (v >> 1) | (fill << (W - 1));
        end
    endfunction

    function automatic int mmode(int v, int m, int d, bit sl, bit sr);
        case (m)
            1:       return mstep(v, 1'b0, 1'b0, sl, sr);
            2:       return mstep(v, 1'b1, 1'b0, sl, sr);
            3:       return d;
            4:       return mstep(v, 1'b0, 1'b1, sl, sr);
            5:       return mstep(v, 1'b1, 1'b1, sl, sr);
            6:       return 0;
            7:       return MASK;
            default: return v;
        endcase
    endfunction

    always @(posedge clockpulse) begin
        if (!clear) begin
            m_val = 0; m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_val  = mstep(m_val, m_dir, m_rot, serial_l, serial_r);
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            if (burst_cnt != 0) begin
                m_left = int'(burst_cnt); m_dir = burst_dir; m_rot = burst_rot;
            end else begin
                m_done = 1;
            end
        end else begin
            m_val = mmode(m_val, int'(mode), int'(data), serial_l, serial_r);
        end
        #1;
        check("model_out", 32'(out), 32'(m_val));
        check("model_notout", 32'(notout), 32'((~m_val) & MASK));
        check("model_busy", 32'(busy), 32'(m_left > 0));
        check("model_done", 32'(done), 32'(m_done));
    end

    task automatic step();
        @(posedge clockpulse);
        #1;
    endtask

    task automatic do_mode(input logic [2:0] m, input logic [W-1:0] exp, input string name);
        mode = m;
        step();
        check(name, 32'(out), 32'(exp));
    endtask

    task automatic kick(input logic dir, input logic rot, input logic [CW-1:0] cnt);
        mode = 3'b000; start = 1'b1; burst_dir = dir; burst_rot = rot; burst_cnt = cnt;
        step();
        start = 1'b0;
    endtask

    initial begin
        clear = 1'b0; mode = 3'b000; data = '0; serial_l = 1'b0; serial_r = 1'b0;
        start = 1'b0; burst_dir = 1'b0; burst_rot = 1'b0; burst_cnt = '0;
        repeat (2) step();
        check("rst_out", 32'(out), 32'h0);
        check("rst_notout", 32'(notout), 32'hF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        clear = 1'b1;

        data = 4'b1001;
        do_mode(3'b011, 4'b1001, "load");
        do_mode(3'b100, 4'b1100, "rot_r");
        do_mode(3'b101, 4'b1001, "rot_l");
        serial_l = 1'b1;
        do_mode(3'b010, 4'b0011, "shl");
        serial_r = 1'b0;
        do_mode(3'b001, 4'b0001, "shr");
        do_mode(3'b110, 4'b0000, "sclr");
        do_mode(3'b111, 4'b1111, "spre");
        for (int i = 0; i < 3; i++) do_mode(3'b000, 4'b1111, "hold");

        // Rotate-left burst of 3 from 0001.
        data = 4'b0001;
        do_mode(3'b011, 4'b0001, "load1");
        kick(1'b1, 1'b1, 3'd3);
        check("b_start_busy", 32'(busy), 32'h1);
        check("b_start_out", 32'(out), 32'h1);
        step(); check("b1_out", 32'(out), 32'h2); check("b1_busy", 32'(busy), 32'h1);
        step(); check("b2_out", 32'(out), 32'h4); check("b2_busy", 32'(busy), 32'h1);
        step(); check("b3_out", 32'(out), 32'h8); check("b3_busy", 32'(busy), 32'h0);
        check("b3_done", 32'(done), 32'h1);
        step(); check("b_done_end", 32'(done), 32'h0);

        // Zero-count start: done pulse only.
        kick(1'b0, 1'b0, 3'd0);
        check("z_done", 32'(done), 32'h1); check("z_busy", 32'(busy), 32'h0);
        check("z_out", 32'(out), 32'h8);
        step(); check("z_done_end", 32'(done), 32'h0);

        // Second start during RUN is ignored.
        kick(1'b0, 1'b1, 3'd2);
        start = 1'b1; burst_cnt = 3'd7;
        step(); start = 1'b0;
        check("ig1_out", 32'(out), 32'h4);
        step(); check("ig2_out", 32'(out), 32'h2); check("ig2_done", 32'(done), 32'h1);
        step(); check("ig3_out", 32'(out), 32'h2); check("ig3_busy", 32'(busy), 32'h0);

        // Shift-right burst of 6 from F with zero fill.
        data = 4'hF;
        do_mode(3'b011, 4'hF, "loadF");
        serial_r = 1'b0;
        kick(1'b0, 1'b0, 3'd6);
        repeat (4) step();
        check("sh4_out", 32'(out), 32'h0); check("sh4_busy", 32'(busy), 32'h1);
        repeat (2) step();
        check("sh6_out", 32'(out), 32'h0); check("sh6_done", 32'(done), 32'h1);
        step();

        // Abort mid-burst with asynchronous clear.
        data = 4'hA;
        do_mode(3'b011, 4'hA, "loadA");
        kick(1'b1, 1'b1, 3'd5);
        step(); check("ab1_out", 32'(out), 32'h5);
        #2 clear = 1'b0;
        #1;
        check("ab_out", 32'(out), 32'h0); check("ab_notout", 32'(notout), 32'hF);
        check("ab_busy", 32'(busy), 32'h0);
        step(); check("ab_nodone", 32'(done), 32'h0);
        clear = 1'b1;
        data = 4'b0011;
        do_mode(3'b011, 4'b0011, "load3");
        kick(1'b1, 1'b1, 3'd2);
        repeat (2) step();
        check("post_out", 32'(out), 32'hC); check("post_done", 32'(done), 32'h1);

        // Randomized phase, checked every cycle by the model process.
        for (int i = 0; i < 3000; i++) begin
            if (!clear) clear = 1'b1;
            else if ($urandom_range(0, 149) == 0) clear = 1'b0;
            mode      = 3'($urandom_range(0, 7));
            data      = 4'($urandom_range(0, 15));
            serial_l  = 1'($urandom_range(0, 1));
            serial_r  = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 4) == 0);
            burst_dir = 1'($urandom_range(0, 1));
            burst_rot = 1'($urandom_range(0, 1));
            burst_cnt = 3'($urandom_range(0, 7));
            step();
        end
        clear = 1'b1; start = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
